alu_bist_sequencer: RTL and testbench

- Synthesizable initiator/checker for the ALU valid_in/valid_out interface; it sits opposite the ALU, which it treats as a black box.
- Generates pseudo-random operand/opcode vectors and drives them into the ALU.
- Computes expected results with an internal golden model, queues them, and compares each against the ALU output on valid_out.
- Reports pass/fail counts and details of the first mismatch, for on-chip self-test of baseline and optimized ALU variants.

---
 rtl/alu_bist_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_bist_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sequencer.sv
// alu_bist_sequencer: drives pseudo-random vectors into an ALU and checks its
// in-order results against a built-in golden model.
module alu_bist_sequencer #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          num_vectors,
   input  logic [31:0]          seed,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [3:0]           alu_op,
   output logic                 alu_valid_in,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   input  logic                 alu_valid_out,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          pass_count,
   output logic [15:0]          fail_count,
   output logic                 timeout_err,
   output logic [4+3*WIDTH-1:0] fail_info
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(WIDTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t state, state_nx;
   logic [31:0] lfsr, lfsr_nx;
   logic [15:0] nv, issued;
   logic [3:0] op_idx;
   logic [AW:0] cnt;
   logic [AW-1:0] wp, rp;
   logic [TW-1:0] tcnt;
   logic failed;
   logic [3:0] q_op [DEPTH];
   logic [WIDTH-1:0] q_a [DEPTH];
   logic [WIDTH-1:0] q_b [DEPTH];
   logic [WIDTH-1:0] q_r [DEPTH];
   logic q_z [DEPTH];
   logic active, launch, full, tmo, issue, last, chk, head_ok, pop;
   logic [WIDTH-1:0] a_n, b_n, r_n;
   logic [4+3*WIDTH-1:0] fi_n;
   logic unused_ovf;

   function automatic logic [WIDTH-1:0] golden(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (op)
         4'd0: golden = a + b;
         4'd1: golden = a - b;
         4'd2: golden = a & b;
         4'd3: golden = a | b;
         4'd4: golden = a ^ b;
         4'd5: golden = a << b[SW-1:0];
         4'd6: golden = a >> b[SW-1:0];
         4'd7: golden = WIDTH'(a < b);
         4'd8: golden = WIDTH'(a == b);
         default: golden = a;
      endcase
   endfunction

   assign unused_ovf = alu_overflow;
   assign busy = (state == ISSUE) || (state == DRAIN);
   assign done = (state == DONE);

   always_comb begin
      active  = busy;
      launch  = start && (state == IDLE || state == DONE);
      full    = cnt == (AW+1)'(DEPTH);
      tmo     = active && cnt != '0 && !alu_valid_out && tcnt == TW'(TIMEOUT - 1);
      issue   = state == ISSUE && issued < nv && !full && !tmo;
      last    = issue && issued == nv - 16'd1;
      chk     = active && alu_valid_out;
      head_ok = cnt != '0 && alu_result == q_r[rp] && alu_zero == q_z[rp];
      pop     = chk && cnt != '0;
      lfsr_nx = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      a_n     = lfsr[WIDTH-1:0];
      b_n     = lfsr[2*WIDTH-1:WIDTH];
      r_n     = golden(op_idx, a_n, b_n);
      // A result with nothing outstanding is reported with opcode 4'hF.
      fi_n    = cnt != '0 ? {q_op[rp], q_a[rp], q_b[rp], alu_result}
                          : {4'hF, {(2*WIDTH){1'b0}}, alu_result};
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (launch) state_nx = (num_vectors == 16'd0) ? DONE : ISSUE;
         ISSUE:      state_nx = tmo ? DONE : last ? DRAIN : ISSUE;
         DRAIN:      state_nx = (tmo || (cnt == '0 && !alu_valid_out)) ? DONE : DRAIN;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         lfsr         <= 32'h1;
         nv           <= '0;
         issued       <= '0;
         op_idx       <= '0;
         cnt          <= '0;
         wp           <= '0;
         rp           <= '0;
         tcnt         <= '0;
         failed       <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         alu_valid_in <= 1'b0;
         pass_count   <= '0;
         fail_count   <= '0;
         timeout_err  <= 1'b0;
         fail_info    <= '0;
      end else begin
         state        <= state_nx;
         alu_valid_in <= issue;
         if (launch) begin
            lfsr        <= (seed == 32'h0) ? 32'h1 : seed;
            nv          <= num_vectors;
            issued      <= '0;
            op_idx      <= '0;
            cnt         <= '0;
            wp          <= '0;
            rp          <= '0;
            tcnt        <= '0;
            failed      <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            timeout_err <= 1'b0;
            fail_info   <= '0;
         end else begin
            if (issue) begin
               alu_a  <= a_n;
               alu_b  <= b_n;
               alu_op <= op_idx;
               lfsr   <= lfsr_nx;
               op_idx <= (op_idx == 4'd9) ? 4'd0 : op_idx + 4'd1;
               issued <= issued + 16'd1;
            end
            cnt  <= tmo ? '0 : cnt + (AW+1)'(issue) - (AW+1)'(pop);
            wp   <= tmo ? '0 : wp + AW'(issue);
            rp   <= tmo ? '0 : rp + AW'(pop);
            tcnt <= (!active || cnt == '0 || alu_valid_out) ? '0 : tcnt + TW'(1);
            if (tmo) timeout_err <= 1'b1;
            if (chk && head_ok && pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            if (chk && !head_ok) begin
               if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
               if (!failed) fail_info <= fi_n;
               failed <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         q_op[wp] <= op_idx;
         q_a[wp]  <= a_n;
         q_b[wp]  <= b_n;
         q_r[wp]  <= r_n;
         q_z[wp]  <= (r_n == '0);
      end
   end
endmodule

// File: tb/tb_alu_bist_sequencer.sv
// tb_alu_bist_sequencer: bench ALU with configurable latency and faults, issue
// scoreboard against a reference vector stream, and end-of-run count checks.
module tb_alu_bist_sequencer;
   localparam int W = 8, D = 4, TO = 64;

   typedef struct { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
   typedef struct { int due; logic [W-1:0] r; logic z; bit drop; } rsp_t;

   logic clk = 0, rst = 0, start = 0;
   logic [15:0] num_vectors = 0;
   logic [31:0] seed = 0;
   logic [W-1:0] alu_a, alu_b, alu_result = 0;
   logic [3:0] alu_op;
   logic alu_valid_in, alu_zero = 0, alu_overflow = 0, alu_valid_out = 0;
   logic busy, done, timeout_err;
   logic [15:0] pass_count, fail_count;
   logic [4+3*W-1:0] fail_info;

   alu_bist_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .seed(seed),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid_in(alu_valid_in),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_valid_out(alu_valid_out), .busy(busy), .done(done), .pass_count(pass_count),
      .fail_count(fail_count), .timeout_err(timeout_err), .fail_info(fail_info)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   vec_t exp_q[$], stream[$];
   rsp_t pipe[$];
   int lat = 2, corrupt_idx = -1, drop_idx = -1, spur_cyc = -1;
   int alu_seen = 0, vo_cnt = 0, max_occ = 0, last_vo = 0, issued_n = 0, cur_nv = 0, done_cyc = 0;
   bit gap = 0;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      int x = int'(a), y = int'(b), m = 1 << W;
      case (op)
         4'd0: return W'((x + y) % m);
         4'd1: return W'((x - y + m) % m);
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return W'((x * (1 << (y % W))) % m);
         4'd6: return W'(x / (1 << (y % W)));
         4'd7: return W'(x < y);
         4'd8: return W'(x == y);
         default: return a;
      endcase
   endfunction

   // Bench ALU: fixed latency, optional corrupted/dropped result and one spurious strobe.
   always @(negedge clk) begin : alu_model
      rsp_t p;
      logic [W-1:0] r;
      alu_valid_out = 0;
      alu_result = '0;
      alu_zero = 0;
      if (rst) pipe.delete();
      else begin
         if (alu_valid_in && alu_seen + 1 - vo_cnt > max_occ) max_occ = alu_seen + 1 - vo_cnt;
         if (pipe.size() > 0 && pipe[0].due == cyc) begin
            p = pipe.pop_front();
            if (!p.drop) begin
               alu_valid_out = 1;
               alu_result = p.r;
               alu_zero = p.z;
               vo_cnt++;
               last_vo = cyc;
            end
         end else if (cyc == spur_cyc) begin
            alu_valid_out = 1;
            alu_result = 8'h5A;
         end
         if (alu_valid_in) begin
            r = alu_ref(alu_op, alu_a, alu_b);
            p.due = cyc + lat;
            p.r = (alu_seen == corrupt_idx) ? r ^ W'(1) : r;
            p.z = (r == '0);
            p.drop = (alu_seen == drop_idx);
            pipe.push_back(p);
            alu_seen++;
         end
      end
   end

   // Issue monitor: every strobe must carry the next vector of the reference stream.
   always @(negedge clk) begin : issue_monitor
      vec_t v;
      if (!rst && alu_valid_in) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra issue: got op %0d a %0h b %0h, expected no issue", alu_op, alu_a, alu_b);
         end else begin
            v = exp_q.pop_front();
            check("issue vector", {alu_op, alu_a, alu_b}, {v.op, v.a, v.b});
         end
         issued_n++;
      end else if (!rst && busy && issued_n > 0 && issued_n < cur_nv) gap = 1;
   end

   task automatic launch(logic [31:0] sd, int n, bit spur);
      logic [31:0] s = (sd == 0) ? 32'h1 : sd;
      vec_t v;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         v.op = 4'(i % 10);
         v.a = s[W-1:0];
         v.b = s[2*W-1:W];
         exp_q.push_back(v);
         s = {s[30:0], ^(s & 32'h8020_0003)};
      end
      stream = exp_q;
      cur_nv = n;
      issued_n = 0;
      gap = 0;
      max_occ = 0;
      alu_seen = 0;
      vo_cnt = 0;
      @(negedge clk);
      seed = sd;
      num_vectors = 16'(n);
      start = 1;
      spur_cyc = spur ? cyc + 1 : -1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      done_cyc = cyc;
      check("run completes", done, 1);
   endtask

   task automatic run(logic [31:0] sd, int n);
      launch(sd, n, 0);
      wait_done(3000);
   endtask

   task automatic end_checks(string tag, int p, int f, bit t);
      check({tag, " pass_count"}, pass_count, p);
      check({tag, " fail_count"}, fail_count, f);
      check({tag, " timeout_err"}, timeout_err, t);
      check({tag, " issued"}, issued_n, cur_nv);
      check({tag, " busy"}, busy, 0);
   endtask

   initial begin
      int n;
      #1 rst = 1;
      repeat (3) @(negedge clk);
      check("reset flags", {alu_valid_in, busy, done, timeout_err}, 0);
      check("reset counts", {pass_count, fail_count}, 0);
      check("reset fail_info", fail_info, 0);
      check("reset vector", {alu_op, alu_a, alu_b}, 0);
      rst = 0;

      run(32'h1, 20);
      end_checks("basic", 20, 0, 0);

      corrupt_idx = 4;
      run(32'h1, 20);
      corrupt_idx = -1;
      end_checks("corrupt", 19, 1, 0);
      check("corrupt fail_info", fail_info,
            {4'd4, stream[4].a, stream[4].b, alu_ref(4'd4, stream[4].a, stream[4].b) ^ W'(1)});

      launch(32'h1234, 0, 0);
      check("zero vectors done", done, 1);
      check("zero vectors counts", {pass_count, fail_count, timeout_err}, 0);
      check("zero vectors fail_info", fail_info, 0);

      lat = 6;
      run($urandom, 30);
      end_checks("latency6", 30, 0, 0);
      check("max outstanding", max_occ, D);
      check("issue gaps seen", gap, 1);
      lat = 2;

      drop_idx = 11;
      run(32'h1, 12);
      drop_idx = -1;
      end_checks("timeout", 11, 0, 1);
      check("timeout latency", done_cyc - last_vo, TO + 1);

      launch(32'h1, 10, 1);
      wait_done(3000);
      spur_cyc = -1;
      end_checks("spurious", 10, 1, 0);
      check("spurious fail_info", fail_info, {4'hF, 16'h0, 8'h5A});

      for (int i = 0; i < 4; i++) begin
         lat = $urandom_range(1, 6);
         n = $urandom_range(1, 40);
         run($urandom, n);
         end_checks("random", n, 0, 0);
      end
      lat = 2;

      launch(32'h1, 20, 0);
      repeat (6) @(negedge clk);
      check("issuing before reset", alu_valid_in, 1);
      #2 rst = 1;
      #1;
      check("reset mid-run valid_in", alu_valid_in, 0);
      check("reset mid-run counts", {pass_count, fail_count}, 0);
      check("reset mid-run flags", {busy, done, timeout_err}, 0);
      check("reset mid-run fail_info", fail_info, 0);
      @(negedge clk);
      rst = 0;
      run(32'h0, 20);
      end_checks("seed0", 20, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
